// File: rtl/snake_pkg.sv
// Shared types and scan codes for the snake PS/2 direction path.
// Direction encoding matches the draw stage: 00 up, 01 right, 10 down, 11 left.
package snake_pkg;

  typedef enum logic [1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} dir_t;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;

  // Opposite directions differ only in the upper encoding bit.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: sync, clock glitch filter, 11-bit frame check, idle timeout.
// key_strobe/frame_err pulse one cycle after the deciding edge; no backpressure, bytes are not buffered.
module ps2_rx
  import snake_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, fall;
  logic [FW-1:0] flt_cnt;
  logic          dat;

  assign dat = dat_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall     <= 1'b0;
      // Level changes only after FILTER_LEN consecutive samples of the new level.
      if (clk_sync[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        flt_cnt  <= '0;
        fall     <= clk_filt;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_d;
  logic          strobe_d, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      rx_byte    <= 8'h00;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      rx_byte    <= byte_d;
      key_strobe <= strobe_d;
      frame_err  <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tmo_d     = (state_q == RX_IDLE || fall) ? '0 : tmo_q + TW'(1);
    byte_d    = rx_byte;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          if (!dat) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (fall) begin
          shreg_d   = {dat, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_d   = dat;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_d = RX_IDLE;
          if (dat && (^{shreg_q, par_q})) begin
            byte_d   = shreg_q;
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
    // A stalled frame is dropped; the shift register contents are simply abandoned.
    if (state_q != RX_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_direction_ctrl.sv
// PS/2 arrow-key decoder feeding snake direction; WASD keys enabled by `PS2_WASD_EN.
// dir_valid follows key_strobe by one cycle; no backpressure, reversals are silently dropped.
module ps2_direction_ctrl
  import snake_pkg::*;
#(
  parameter int         FILTER_LEN     = 4,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [1:0] RESET_DIR      = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] direction,
  output logic       dir_valid,
  output logic       key_strobe,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

`ifdef PS2_WASD_EN
  localparam bit WASD_EN = 1'b1;
`else
  localparam bit WASD_EN = 1'b0;
`endif

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .key_strobe(key_strobe),
    .frame_err (frame_err)
  );

  dec_state_t dec_q, dec_d;
  logic       req_vld;
  dir_t       req_dir, dir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dec_q <= DEC_BASE;
    else       dec_q <= dec_d;
  end

  always_comb begin
    dec_d   = dec_q;
    req_vld = 1'b0;
    req_dir = UP;
    if (key_strobe) begin
      case (dec_q)
        DEC_BASE: begin
          if (rx_byte == SC_EXT)      dec_d = DEC_EXT;
          else if (rx_byte == SC_BRK) dec_d = DEC_BRK;
          else if (WASD_EN) begin
            req_vld = 1'b1;
            case (rx_byte)
              SC_W:    req_dir = UP;
              SC_D:    req_dir = RIGHT;
              SC_S:    req_dir = DOWN;
              SC_A:    req_dir = LEFT;
              default: req_vld = 1'b0;
            endcase
          end
        end
        DEC_EXT: begin
          if (rx_byte == SC_BRK) begin
            dec_d = DEC_EXT_BRK;
          end else begin
            dec_d   = DEC_BASE;
            req_vld = 1'b1;
            case (rx_byte)
              SC_UP:    req_dir = UP;
              SC_RIGHT: req_dir = RIGHT;
              SC_DOWN:  req_dir = DOWN;
              SC_LEFT:  req_dir = LEFT;
              default:  req_vld = 1'b0;
            endcase
          end
        end
        // Break states swallow the released key's code.
        default: dec_d = DEC_BASE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q     <= dir_t'(RESET_DIR);
      dir_valid <= 1'b0;
    end else begin
      dir_valid <= 1'b0;
      if (req_vld && !is_reverse(req_dir, dir_q)) begin
        dir_q     <= req_dir;
        dir_valid <= 1'b1;
      end
    end
  end

  assign direction = dir_q;

endmodule

// File: tb/tb_ps2_direction_ctrl.sv
// Directed and random PS/2 frames checked against a keystroke-level reference model.
module tb_ps2_direction_ctrl;

  localparam int TMO  = 300;
  localparam int HALF = 12;

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_data;
  logic [1:0] direction;
  logic       dir_valid, key_strobe, frame_err;
  logic [7:0] rx_byte;

  ps2_direction_ctrl #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TMO),
    .RESET_DIR     (2'b01)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .direction (direction),
    .dir_valid (dir_valid),
    .key_strobe(key_strobe),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int ks_cnt = 0, dv_cnt = 0, fe_cnt = 0;
  int exp_ks = 0, exp_dv = 0, exp_fe = 0;
  logic [1:0] exp_dir = 2'b01;
  logic [7:0] exp_rx  = 8'h00;
  bit pend_ext = 1'b0, pend_brk = 1'b0;
  logic ks_prev = 1'b0;

`ifdef PS2_WASD_EN
  localparam bit WASD = 1'b1;
`else
  localparam bit WASD = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters; every dir_valid must come right after a key_strobe.
  always @(negedge clk) begin
    if (reset) begin
      ks_cnt = 0; dv_cnt = 0; fe_cnt = 0;
    end else begin
      if (key_strobe) ks_cnt++;
      if (frame_err) fe_cnt++;
      if (dir_valid) begin
        dv_cnt++;
        check("dv_latency", {31'd0, ks_prev}, 32'd1);
      end
    end
    ks_prev = key_strobe;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // Keystroke semantics: a break code swallows the next byte, E0 qualifies the next byte.
  task automatic model_byte(input logic [7:0] b);
    int  req;
    bit  has;
    bit  was_ext;
    has = 1'b0;
    req = 0;
    if (pend_brk) begin
      pend_brk = 1'b0;
      return;
    end
    if (b == 8'hF0) begin
      pend_brk = 1'b1;
      pend_ext = 1'b0;
      return;
    end
    was_ext  = pend_ext;
    pend_ext = 1'b0;
    if (was_ext) begin
      case (b)
        8'h75: begin req = 0; has = 1'b1; end
        8'h74: begin req = 1; has = 1'b1; end
        8'h72: begin req = 2; has = 1'b1; end
        8'h6B: begin req = 3; has = 1'b1; end
        default: ;
      endcase
    end else if (b == 8'hE0) begin
      pend_ext = 1'b1;
    end else if (WASD) begin
      case (b)
        8'h1D: begin req = 0; has = 1'b1; end
        8'h23: begin req = 1; has = 1'b1; end
        8'h1B: begin req = 2; has = 1'b1; end
        8'h1C: begin req = 3; has = 1'b1; end
        default: ;
      endcase
    end
    if (has && ((req - int'(exp_dir) + 4) % 4) != 2) begin
      exp_dir = req[1:0];
      exp_dv++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".direction"}, {30'd0, direction}, {30'd0, exp_dir});
    check({tag, ".rx_byte"}, {24'd0, rx_byte}, {24'd0, exp_rx});
    check({tag, ".key_strobes"}, ks_cnt, exp_ks);
    check({tag, ".dir_valids"}, dv_cnt, exp_dv);
    check({tag, ".frame_errs"}, fe_cnt, exp_fe);
  endtask

  task automatic xfer(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(~(^b) ^ bad_par);
    drive_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cyc(30);
    if (bad_par || bad_stop) begin
      exp_fe++;
    end else begin
      exp_ks++;
      exp_rx = b;
      model_byte(b);
    end
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    check("reset.direction", {30'd0, direction}, 32'd1);
    check("reset.rx_byte", {24'd0, rx_byte}, 32'd0);
    check("reset.pulses", {29'd0, dir_valid, key_strobe, frame_err}, 32'd0);
    reset = 1'b0;
    exp_ks = 0; exp_dv = 0; exp_fe = 0;
    exp_dir = 2'b01; exp_rx = 8'h00;
    pend_ext = 1'b0; pend_brk = 1'b0;
    wait_cyc(5);
  endtask

  logic [7:0] pool [12];
  initial begin
    pool = '{8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B,
             8'h1D, 8'h23, 8'h1B, 8'h1C};

    do_reset();
    check_all("idle");

    xfer("up_e0", 8'hE0, 1'b0, 1'b0);
    xfer("up_75", 8'h75, 1'b0, 1'b0);
    check("up.dir_const", {30'd0, direction}, 32'd0);
    check("up.dv_once", dv_cnt, 32'd1);
    check("up.ks_twice", ks_cnt, 32'd2);

    xfer("down_e0", 8'hE0, 1'b0, 1'b0);
    xfer("down_72", 8'h72, 1'b0, 1'b0);
    check("reverse.dir_const", {30'd0, direction}, 32'd0);

    xfer("left_e0", 8'hE0, 1'b0, 1'b0);
    xfer("left_6b", 8'h6B, 1'b0, 1'b0);
    xfer("brk_e0", 8'hE0, 1'b0, 1'b0);
    xfer("brk_f0", 8'hF0, 1'b0, 1'b0);
    xfer("brk_6b", 8'h6B, 1'b0, 1'b0);
    check("left.dir_const", {30'd0, direction}, 32'd3);
    check("left.dv_total", dv_cnt, 32'd2);

    xfer("badpar_74", 8'h74, 1'b1, 1'b0);
    check("badpar.rx_held", {24'd0, rx_byte}, 32'h6B);
    xfer("badstop_75", 8'h75, 1'b0, 1'b1);

    // Abandon a frame after four data bits.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    ps2_data = 1'b1;
    wait_cyc(TMO + 20);
    exp_fe++;
    check_all("timeout");
    xfer("post_tmo_e0a", 8'hE0, 1'b0, 1'b0);
    xfer("post_tmo_75", 8'h75, 1'b0, 1'b0);
    xfer("post_tmo_e0b", 8'hE0, 1'b0, 1'b0);
    xfer("post_tmo_74", 8'h74, 1'b0, 1'b0);
    check("post_tmo.dir_const", {30'd0, direction}, 32'd1);

    // Two-cycle clock glitch with data low must not start a frame.
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(TMO + 20);
    check_all("glitch");
    xfer("post_glitch_e0", 8'hE0, 1'b0, 1'b0);
    xfer("post_glitch_72", 8'h72, 1'b0, 1'b0);

    xfer("typematic_e0a", 8'hE0, 1'b0, 1'b0);
    xfer("typematic_72a", 8'h72, 1'b0, 1'b0);
    xfer("wasd_1d", 8'h1D, 1'b0, 1'b0);
    xfer("wasd_1c", 8'h1C, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    xfer("mid_e0", 8'hE0, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    do_reset();
    check_all("mid_reset");

    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      int sel, bad;
      sel = $urandom_range(0, 14);
      b   = (sel < 12) ? pool[sel] : 8'($urandom);
      bad = $urandom_range(0, 9);
      xfer($sformatf("rand%0d", n), b, bad == 0, bad == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
